motoro3_step_sequencer: RTL and testbench
=========================================

Name: motoro3_step_sequencer

Overview:
Timebase and commutation sequencer for one three-phase motor channel. It generates the sub-step counter `m3cnt` and its first/last flags, the split-step index, the 6-step commutation step `lgStep`, and the PWM activity qualifiers. All of these are consumed directly by the line generator for phases A/B/C. Step rate, split count and direction are taken from register inputs and applied only at safe boundaries.

Parameters:
- CNT_W, 25, width of `m3cnt` and `m3r_stepCNT_speedSET`.
- MIN_PERIOD, 4, minimum effective sub-step period in clocks; smaller settings are clamped up to this value.

Ports:
- `clk`  in  1  system clock (10 MHz).
- `rst`  in  1  synchronous reset, active-high.
- `m3r_run`  in  1  run request; level-sensitive.
- `m3r_dirRev`  in  1  0 = forward (1→6), 1 = reverse (6→1).
- `m3r_stepCNT_speedSET`  in  CNT_W  clocks per split sub-step.
- `m3r_stepSplitMax`  in  2  split sub-steps per commutation step, minus 1.
- `m3cnt`  out  CNT_W  sub-step clock counter.
- `m3cntFirst1`  out  1  high when `m3cnt` == 0.
- `m3cntFirst2`  out  1  high when `m3cnt` == 1.
- `m3cntLast1`  out  1  high when `m3cnt` == P-1.
- `m3cntLast2`  out  1  high when `m3cnt` == P-2.
- `m3LpwmSplitStep`  out  2  current split index, 0..S.
- `lgStep`  out  4  0 = all MOS off; 1..6 = commutation steps; 7..15 never driven.
- `pwmActive1`  out  1  high while sequencing (RUN or STOP_PEND).
- `pwmLastStep1`  out  1  high while `pwmActive1` and `m3LpwmSplitStep` == S.

Behaviour:
- All outputs are registered. Every flag is valid in the same cycle as the `m3cnt` value it describes.
- Reset (sync, any state, including mid-step): the next edge gives state IDLE and all outputs 0, including `lgStep` = 0. Latched P, S and dir are cleared to MIN_PERIOD, 0 and 0.
- P = latched max(`m3r_stepCNT_speedSET`, MIN_PERIOD). S = latched `m3r_stepSplitMax`. dir = latched `m3r_dirRev`.
- FSM states: IDLE, RUN, STOP_PEND.
- IDLE:
  - Outputs are 0.
  - If `m3r_run` = 1 at an edge, latch P, S and dir. At the same edge go to RUN with `m3cnt` = 0, First1 = 1, split = 0, `lgStep` = 1 (forward) or 6 (reverse), `pwmActive1` = 1.
  - Latency from run sampled high to first active output: 1 clock.
- RUN, sub-step counting:
  - `m3cnt` increments each clock.
  - When `m3cnt` == P-1 (Last1), the next value wraps to 0.
  - On wrap: if split < S, split increments. If split == S, this is a commutation boundary.
- Commutation boundary:
  - split goes to 0.
  - `lgStep` advances: forward 1→2→…→6→1; reverse 6→5→…→1→6.
  - P, S and dir are re-latched from the registers at this edge. Changes made mid-step therefore never alter the current step.
  - The new dir applies to this advance.
- Run deassert:
  - `m3r_run` = 0 in RUN moves to STOP_PEND, with no output discontinuity.
  - STOP_PEND keeps counting. At the next commutation boundary, go to IDLE with all outputs 0; no new step is emitted.
  - If `m3r_run` returns to 1 while in STOP_PEND, go back to RUN and continue uninterrupted.
- Simultaneous events:
  - Reset has priority over everything.
  - If run deasserts in the same cycle as a commutation boundary in RUN, the boundary still advances the step and the FSM enters STOP_PEND. That step then completes in full.
- Flag rules:
  - P ≥ 4 guarantees First1, First2, Last2 and Last1 are mutually exclusive.
  - `m3cnt` never exceeds P-1.
  - No arithmetic overflow: P-1 and P-2 are computed at CNT_W bits, which is valid because P ≥ 4.
- `pwmLastStep1` equals `pwmActive1` AND (split == S). When S = 0 it is high for every active cycle.

Test Plan:
1. Reset; run = 1, speedSET = 10, splitMax = 1, fwd → `lgStep` = 1 one clock after run. `m3cnt` counts 0..9 with First1@0, First2@1, Last2@8, Last1@9. Split goes 0 then 1. `lgStep` = 2 at clock 20, and reaches 1 again at clock 120.
2. speedSET = 2, splitMax = 0 → period clamps to 4. `m3cnt` runs 0..3. `pwmLastStep1` is constantly 1. `lgStep` advances every 4 clocks.
3. Mid-step, change speedSET 10→20 and set dirRev = 1 while `lgStep` = 3 → current step keeps period 10. At the boundary `lgStep` becomes 2 (not 4), and the next `m3cnt` wrap occurs at 19.
4. Drop run at `m3cnt` = 3 during `lgStep` = 4 → sequence continues until the split/Last1 boundary. At the next clock all outputs are 0 and `lgStep` = 0; no step 5 appears.
5. Drop run, then re-raise it before the boundary → no gap. Step advances normally and `pwmActive1` never drops.
6. Assert rst for 1 cycle at `m3cnt` = 5, `lgStep` = 6 → next clock all outputs are 0 and state is IDLE. With run still 1, the following clock restarts at `lgStep` = 1, `m3cnt` = 0.

Source files
------------

// File: rtl/motoro3_step_sequencer.sv
// -----------------------------------------------------------------------------
// motoro3_step_sequencer
// Timebase and 6-step commutation sequencer for one three-phase motor channel.
// Produces the sub-step counter, its first/last flags, the split-step index,
// the commutation step and the PWM activity qualifiers for the line generator.
// Step period, split count and direction are latched only when a run starts
// or at a commutation boundary, so register writes never disturb a step that
// is already in progress.
//
// Ports:
//   clk                   system clock
//   rst                   synchronous reset, active-high
//   m3r_run               run request (level)
//   m3r_dirRev            0 = forward (1..6), 1 = reverse (6..1)
//   m3r_stepCNT_speedSET  clocks per split sub-step (clamped to MIN_PERIOD)
//   m3r_stepSplitMax      split sub-steps per commutation step, minus 1
//   m3cnt                 sub-step clock counter, 0..P-1
//   m3cntFirst1/2         m3cnt == 0 / m3cnt == 1
//   m3cntLast1/2          m3cnt == P-1 / m3cnt == P-2
//   m3LpwmSplitStep       current split index, 0..S
//   lgStep                0 = all off, 1..6 = commutation step
//   pwmActive1            high while sequencing
//   pwmLastStep1          pwmActive1 and split index == S
// -----------------------------------------------------------------------------
module motoro3_step_sequencer #(
    parameter int CNT_W      = 25,
    parameter int MIN_PERIOD = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             m3r_run,
    input  logic             m3r_dirRev,
    input  logic [CNT_W-1:0] m3r_stepCNT_speedSET,
    input  logic [1:0]       m3r_stepSplitMax,
    output logic [CNT_W-1:0] m3cnt,
    output logic             m3cntFirst1,
    output logic             m3cntFirst2,
    output logic             m3cntLast1,
    output logic             m3cntLast2,
    output logic [1:0]       m3LpwmSplitStep,
    output logic [3:0]       lgStep,
    output logic             pwmActive1,
    output logic             pwmLastStep1
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RUN       = 2'd1,
        STOP_PEND = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] MIN_P = CNT_W'(MIN_PERIOD);

    // Next commutation step in the requested direction, wrapping 6<->1.
    function automatic logic [3:0] advanceStep(input logic [3:0] step, input logic rev);
        logic [3:0] res;
        if (rev) begin
            case (step)
                4'd1:    res = 4'd6;
                4'd2:    res = 4'd1;
                4'd3:    res = 4'd2;
                4'd4:    res = 4'd3;
                4'd5:    res = 4'd4;
                4'd6:    res = 4'd5;
                default: res = 4'd6;
            endcase
        end else begin
            case (step)
                4'd1:    res = 4'd2;
                4'd2:    res = 4'd3;
                4'd3:    res = 4'd4;
                4'd4:    res = 4'd5;
                4'd5:    res = 4'd6;
                4'd6:    res = 4'd1;
                default: res = 4'd1;
            endcase
        end
        return res;
    endfunction

    state_t           state_r;
    logic [CNT_W-1:0] periodLat_r;
    logic [1:0]       splitMaxLat_r;
    logic             dirLat_r;

    state_t           stateNext_s;
    logic [CNT_W-1:0] periodNext_s;
    logic [1:0]       splitMaxNext_s;
    logic             dirNext_s;
    logic [CNT_W-1:0] cntNext_s;
    logic [1:0]       splitNext_s;
    logic [3:0]       stepNext_s;
    logic             activeNext_s;
    logic [CNT_W-1:0] speedClamp_s;
    logic             boundary_s;

    // Period request clamped up to the minimum that keeps the four flags distinct.
    assign speedClamp_s = (m3r_stepCNT_speedSET < MIN_P) ? MIN_P : m3r_stepCNT_speedSET;

    // Last clock of the last split sub-step of the current commutation step.
    assign boundary_s = pwmActive1 && m3cntLast1 && (m3LpwmSplitStep == splitMaxLat_r);

    // Next-state and next-output computation for the sequencer.
    always_comb begin
        stateNext_s    = state_r;
        periodNext_s   = periodLat_r;
        splitMaxNext_s = splitMaxLat_r;
        dirNext_s      = dirLat_r;
        cntNext_s      = {CNT_W{1'b0}};
        splitNext_s    = 2'd0;
        stepNext_s     = 4'd0;
        case (state_r)
            IDLE: begin
                if (m3r_run) begin
                    stateNext_s    = RUN;
                    periodNext_s   = speedClamp_s;
                    splitMaxNext_s = m3r_stepSplitMax;
                    dirNext_s      = m3r_dirRev;
                    stepNext_s     = m3r_dirRev ? 4'd6 : 4'd1;
                end else begin
                    stateNext_s = IDLE;
                end
            end
            RUN, STOP_PEND: begin
                if (boundary_s) begin
                    if ((state_r == STOP_PEND) && !m3r_run) begin
                        // Pending stop completes here; no new step is emitted.
                        stateNext_s = IDLE;
                    end else begin
                        // New settings take effect for the step being entered,
                        // including the direction of this very advance.
                        stateNext_s    = m3r_run ? RUN : STOP_PEND;
                        periodNext_s   = speedClamp_s;
                        splitMaxNext_s = m3r_stepSplitMax;
                        dirNext_s      = m3r_dirRev;
                        stepNext_s     = advanceStep(lgStep, m3r_dirRev);
                    end
                end else begin
                    stateNext_s = m3r_run ? RUN : STOP_PEND;
                    stepNext_s  = lgStep;
                    if (m3cntLast1) begin
                        splitNext_s = m3LpwmSplitStep + 2'd1;
                    end else begin
                        cntNext_s   = m3cnt + CNT_W'(1);
                        splitNext_s = m3LpwmSplitStep;
                    end
                end
            end
            default: begin
                stateNext_s = IDLE;
            end
        endcase
        activeNext_s = (stateNext_s != IDLE);
    end

    // State, latched settings and registered outputs; flags are derived from
    // the next count so they line up with the m3cnt value they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r         <= IDLE;
            periodLat_r     <= MIN_P;
            splitMaxLat_r   <= 2'd0;
            dirLat_r        <= 1'b0;
            m3cnt           <= {CNT_W{1'b0}};
            m3cntFirst1     <= 1'b0;
            m3cntFirst2     <= 1'b0;
            m3cntLast1      <= 1'b0;
            m3cntLast2      <= 1'b0;
            m3LpwmSplitStep <= 2'd0;
            lgStep          <= 4'd0;
            pwmActive1      <= 1'b0;
            pwmLastStep1    <= 1'b0;
        end else begin
            state_r         <= stateNext_s;
            periodLat_r     <= periodNext_s;
            splitMaxLat_r   <= splitMaxNext_s;
            dirLat_r        <= dirNext_s;
            m3cnt           <= cntNext_s;
            m3cntFirst1     <= activeNext_s && (cntNext_s == CNT_W'(0));
            m3cntFirst2     <= activeNext_s && (cntNext_s == CNT_W'(1));
            m3cntLast1      <= activeNext_s && (cntNext_s == (periodNext_s - CNT_W'(1)));
            m3cntLast2      <= activeNext_s && (cntNext_s == (periodNext_s - CNT_W'(2)));
            m3LpwmSplitStep <= splitNext_s;
            lgStep          <= stepNext_s;
            pwmActive1      <= activeNext_s;
            pwmLastStep1    <= activeNext_s && (splitNext_s == splitMaxNext_s);
        end
    end

endmodule

// File: tb/tb_motoro3_step_sequencer.sv
// -----------------------------------------------------------------------------
// tb_motoro3_step_sequencer
// Directed self-checking bench for motoro3_step_sequencer. Expected values are
// written from closed-form step/count formulas for each scenario.
// -----------------------------------------------------------------------------
module tb_motoro3_step_sequencer;

    localparam int CNT_W = 25;

    logic             clk;
    logic             rst;
    logic             m3r_run;
    logic             m3r_dirRev;
    logic [CNT_W-1:0] m3r_stepCNT_speedSET;
    logic [1:0]       m3r_stepSplitMax;
    logic [CNT_W-1:0] m3cnt;
    logic             m3cntFirst1;
    logic             m3cntFirst2;
    logic             m3cntLast1;
    logic             m3cntLast2;
    logic [1:0]       m3LpwmSplitStep;
    logic [3:0]       lgStep;
    logic             pwmActive1;
    logic             pwmLastStep1;

    int assertCount;
    int failCount;

    motoro3_step_sequencer #(.CNT_W(CNT_W), .MIN_PERIOD(4)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .m3r_run              (m3r_run),
        .m3r_dirRev           (m3r_dirRev),
        .m3r_stepCNT_speedSET (m3r_stepCNT_speedSET),
        .m3r_stepSplitMax     (m3r_stepSplitMax),
        .m3cnt                (m3cnt),
        .m3cntFirst1          (m3cntFirst1),
        .m3cntFirst2          (m3cntFirst2),
        .m3cntLast1           (m3cntLast1),
        .m3cntLast2           (m3cntLast2),
        .m3LpwmSplitStep      (m3LpwmSplitStep),
        .lgStep               (lgStep),
        .pwmActive1           (pwmActive1),
        .pwmLastStep1         (pwmLastStep1)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        assertCount++;
        if (got !== exp) begin
            failCount++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Compare every output against one expected sequencer snapshot.
    task automatic expectOut(input string tag, input int eCnt, input int eSplit,
                             input int eStep, input bit eAct, input int eS, input int eP);
        checkVal({tag, ".cnt"},    32'(m3cnt),           eAct ? 32'(eCnt) : 32'd0);
        checkVal({tag, ".first1"}, 32'(m3cntFirst1),     32'(eAct && (eCnt == 0)));
        checkVal({tag, ".first2"}, 32'(m3cntFirst2),     32'(eAct && (eCnt == 1)));
        checkVal({tag, ".last1"},  32'(m3cntLast1),      32'(eAct && (eCnt == eP - 1)));
        checkVal({tag, ".last2"},  32'(m3cntLast2),      32'(eAct && (eCnt == eP - 2)));
        checkVal({tag, ".split"},  32'(m3LpwmSplitStep), eAct ? 32'(eSplit) : 32'd0);
        checkVal({tag, ".step"},   32'(lgStep),          eAct ? 32'(eStep) : 32'd0);
        checkVal({tag, ".act"},    32'(pwmActive1),      32'(eAct));
        checkVal({tag, ".lastS"},  32'(pwmLastStep1),    32'(eAct && (eSplit == eS)));
    endtask

    // Advance one clock; outputs are stable 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset the DUT and start a run; returns with the first active cycle (k=0) visible.
    task automatic startRun(input int speed, input int splitMax, input bit rev);
        m3r_run = 1'b0;
        rst     = 1'b1;
        tick();
        rst                  = 1'b0;
        m3r_stepCNT_speedSET = CNT_W'(speed);
        m3r_stepSplitMax     = 2'(splitMax);
        m3r_dirRev           = rev;
        m3r_run              = 1'b1;
        tick();
    endtask

    initial begin
        assertCount          = 0;
        failCount            = 0;
        rst                  = 1'b1;
        m3r_run              = 1'b1;
        m3r_dirRev           = 1'b0;
        m3r_stepCNT_speedSET = CNT_W'(10);
        m3r_stepSplitMax     = 2'd1;

        // Reset holds everything at zero even with run requested.
        tick();
        tick();
        expectOut("rst", 0, 0, 0, 1'b0, 0, 4);

        // 1: P=10, S=1, forward; 20 clocks per step, back to step 1 at k=120.
        startRun(10, 1, 1'b0);
        for (int k = 0; k <= 120; k++) begin
            expectOut($sformatf("t1.k%0d", k), k % 10, (k / 10) % 2, ((k / 20) % 6) + 1, 1'b1, 1, 10);
            if (k < 120) tick();
        end

        // 2: request P=2 clamps to 4, S=0 so lastStep is always high.
        startRun(2, 0, 1'b0);
        for (int k = 0; k < 32; k++) begin
            expectOut($sformatf("t2.k%0d", k), k % 4, 0, ((k / 4) % 6) + 1, 1'b1, 0, 4);
            tick();
        end

        // 3: mid-step change of period and direction during step 3.
        startRun(10, 0, 1'b0);
        for (int k = 0; k <= 50; k++) begin
            if (k < 30) begin
                expectOut($sformatf("t3.k%0d", k), k % 10, 0, (k / 10) + 1, 1'b1, 0, 10);
            end else if (k < 50) begin
                expectOut($sformatf("t3.k%0d", k), k - 30, 0, 2, 1'b1, 0, 20);
            end else begin
                expectOut($sformatf("t3.k%0d", k), 0, 0, 1, 1'b1, 0, 20);
            end
            if (k == 25) begin
                m3r_stepCNT_speedSET = CNT_W'(20);
                m3r_dirRev           = 1'b1;
            end
            tick();
        end

        // 4: drop run at cnt=3 of step 4; step 4 finishes, then everything is off.
        startRun(10, 1, 1'b0);
        for (int k = 0; k <= 85; k++) begin
            if (k < 80) begin
                expectOut($sformatf("t4.k%0d", k), k % 10, (k / 10) % 2, (k / 20) + 1, 1'b1, 1, 10);
            end else begin
                expectOut($sformatf("t4.k%0d", k), 0, 0, 0, 1'b0, 1, 10);
            end
            if (k == 63) m3r_run = 1'b0;
            tick();
        end

        // 5: short drop/re-raise is seamless; a drop landing on a boundary
        //    still advances the step, which then completes before stopping.
        startRun(4, 0, 1'b0);
        for (int k = 0; k <= 17; k++) begin
            if (k < 16) begin
                expectOut($sformatf("t5.k%0d", k), k % 4, 0, (k / 4) + 1, 1'b1, 0, 4);
            end else begin
                expectOut($sformatf("t5.k%0d", k), 0, 0, 0, 1'b0, 0, 4);
            end
            if (k == 5)  m3r_run = 1'b0;
            if (k == 6)  m3r_run = 1'b1;
            if (k == 11) m3r_run = 1'b0;
            tick();
        end

        // 6: one-cycle reset at cnt=5 of step 6, then restart from step 1.
        startRun(10, 0, 1'b0);
        for (int k = 0; k <= 55; k++) begin
            expectOut($sformatf("t6.k%0d", k), k % 10, 0, (k / 10) + 1, 1'b1, 0, 10);
            if (k < 55) tick();
        end
        rst = 1'b1;
        tick();
        expectOut("t6.rst", 0, 0, 0, 1'b0, 0, 10);
        rst = 1'b0;
        tick();
        expectOut("t6.restart", 0, 0, 1, 1'b1, 0, 10);
        tick();
        expectOut("t6.restart1", 1, 0, 1, 1'b1, 0, 10);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
